// File: rtl/accel_issue_throttle.sv
// accel_issue_throttle: caps in-flight accelerator requests, latches errors, and raises a sticky done.
// Optional ACCEL_THROTTLE_STATS_EN adds stall and response counters.
package accel_issue_throttle_pkg;
    typedef struct packed {
        logic [31:0] insn;
        logic [63:0] rs1;
    } accel_req_t;
    typedef struct packed {
        logic        error;
        logic [63:0] result;
    } accel_resp_t;
endpackage

module accel_issue_throttle #(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned CntW = $clog2(MaxOutstanding + 1),
    parameter type req_t = accel_issue_throttle_pkg::accel_req_t,
    parameter type resp_t = accel_issue_throttle_pkg::accel_resp_t
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  req_t            s_req_i,
    input  logic            s_req_valid_i,
    output logic            s_req_ready_o,
    output req_t            m_req_o,
    output logic            m_req_valid_o,
    input  logic            m_req_ready_i,
    input  resp_t           m_resp_i,
    input  logic            m_resp_valid_i,
    output logic            m_resp_ready_o,
    output resp_t           s_resp_o,
    output logic            s_resp_valid_o,
    input  logic            eos_i,
    input  logic            ara_idle_i,
    output logic [CntW-1:0] outstanding_o,
`ifdef ACCEL_THROTTLE_STATS_EN
    output logic [31:0]     stall_cycles_o,
    output logic [31:0]     resp_cnt_o,
`endif
    output logic            err_o,
    output logic            done_o
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            full, inc, dec;

    assign full           = cnt_q == CntW'(MaxOutstanding);
    assign m_req_o        = s_req_i;
    assign m_req_valid_o  = s_req_valid_i & ~full & ~done_o;
    assign s_req_ready_o  = m_req_ready_i & ~full & ~done_o;
    assign m_resp_ready_o = 1'b1;
    assign s_resp_o       = m_resp_i;
    assign s_resp_valid_o = m_resp_valid_i;
    assign inc            = m_req_valid_o & m_req_ready_i;
    assign dec            = m_resp_valid_i;
    assign outstanding_o  = cnt_q;
    assign err_o          = err_q;

    // A response with nothing in flight is a protocol error; the count floors at zero.
    always_comb begin
        cnt_d = (inc & ~dec) ? cnt_q + CntW'(1) :
                (dec & ~inc & cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;
        err_d = err_q | (dec & ~inc & cnt_q == '0) | (dec & m_resp_i.error);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = eos_i ? DRAIN : RUN;
            DRAIN:   state_d = ~eos_i ? RUN :
                               (cnt_q == '0 & ara_idle_i & ~inc & ~dec) ? DONE : DRAIN;
            default: state_d = DONE;
        endcase
    end

    always_comb begin
        done_o = state_q == DONE;
    end

`ifdef ACCEL_THROTTLE_STATS_EN
    logic [31:0] stall_q, stall_d, resp_q, resp_d;

    always_comb begin
        stall_d = stall_q + {31'd0, s_req_valid_i & full & ~done_o & ~&stall_q};
        resp_d  = resp_q + {31'd0, m_resp_valid_i & ~&resp_q};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
            resp_q  <= '0;
        end else begin
            stall_q <= stall_d;
            resp_q  <= resp_d;
        end
    end

    assign stall_cycles_o = stall_q;
    assign resp_cnt_o     = resp_q;
`endif
endmodule

// File: tb/tb_accel_issue_throttle.sv
// tb_accel_issue_throttle: directed checks of throttling, error latching, completion and async reset.
module tb_accel_issue_throttle;
    import accel_issue_throttle_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    accel_req_t  s_req;
    logic        s_req_valid, s_req_ready, m_req_valid, m_req_ready;
    accel_req_t  m_req;
    accel_resp_t m_resp, s_resp;
    logic        m_resp_valid, m_resp_ready, s_resp_valid;
    logic        eos, ara_idle, err, done;
    logic [2:0]  outstanding;
`ifdef ACCEL_THROTTLE_STATS_EN
    logic [31:0] stall_cycles, resp_cnt;
`endif
    int n_chk = 0;
    int n_fail = 0;

    accel_issue_throttle #(.MaxOutstanding(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_req_i(s_req), .s_req_valid_i(s_req_valid), .s_req_ready_o(s_req_ready),
        .m_req_o(m_req), .m_req_valid_o(m_req_valid), .m_req_ready_i(m_req_ready),
        .m_resp_i(m_resp), .m_resp_valid_i(m_resp_valid), .m_resp_ready_o(m_resp_ready),
        .s_resp_o(s_resp), .s_resp_valid_o(s_resp_valid),
        .eos_i(eos), .ara_idle_i(ara_idle), .outstanding_o(outstanding),
`ifdef ACCEL_THROTTLE_STATS_EN
        .stall_cycles_o(stall_cycles), .resp_cnt_o(resp_cnt),
`endif
        .err_o(err), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        s_req = '0; s_req_valid = 0; m_req_ready = 0;
        m_resp = '0; m_resp_valid = 0; eos = 0; ara_idle = 0;
        #1 rst = 1;
        #2;
        chk("reset_cnt", 64'(outstanding), 0);
        chk("reset_err", 64'(err), 0);
        chk("reset_done", 64'(done), 0);
        chk("resp_ready_always", 64'(m_resp_ready), 1);
        #9 rst = 0;
        tick(1);
        // Ara not ready: valid forwarded, nothing accepted
        s_req_valid = 1; s_req.insn = 32'hA0;
        #1;
        chk("mvalid_no_ready", 64'(m_req_valid), 1);
        chk("sready_no_ready", 64'(s_req_ready), 0);
        chk("req_passthru", 64'(m_req.insn), 64'hA0);
        tick(1);
        chk("cnt_no_ready", 64'(outstanding), 0);
        // Six requests offered, four accepted
        m_req_ready = 1;
        for (int i = 0; i < 6; i++) begin
            s_req.insn = 32'(i + 1);
            #1;
            chk($sformatf("fill_ready_%0d", i), 64'(s_req_ready), (i < 4) ? 1 : 0);
            chk($sformatf("fill_mvalid_%0d", i), 64'(m_req_valid), (i < 4) ? 1 : 0);
            tick(1);
        end
        s_req_valid = 0;
        chk("cnt_full", 64'(outstanding), 4);
        // One response frees a slot, next request refills
        m_resp_valid = 1; m_resp.result = 64'h55;
        #1;
        chk("resp_valid_fwd", 64'(s_resp_valid), 1);
        chk("resp_data_fwd", s_resp.result, 64'h55);
        tick(1);
        m_resp_valid = 0;
        chk("cnt_after_resp", 64'(outstanding), 3);
        s_req_valid = 1;
        #1;
        chk("refill_ready", 64'(s_req_ready), 1);
        tick(1);
        s_req_valid = 0;
        chk("cnt_refill", 64'(outstanding), 4);
        // Drain to 2, then simultaneous handshake and response
        m_resp_valid = 1;
        tick(2);
        chk("cnt_two", 64'(outstanding), 2);
        s_req_valid = 1;
        tick(1);
        s_req_valid = 0;
        chk("cnt_simul", 64'(outstanding), 2);
        tick(2);
        chk("cnt_zero", 64'(outstanding), 0);
        chk("err_clean", 64'(err), 0);
        tick(1);
        m_resp_valid = 0;
        chk("spurious_err", 64'(err), 1);
        chk("spurious_cnt", 64'(outstanding), 0);
        tick(1);
        chk("err_sticky", 64'(err), 1);
        // Three in flight, then async reset between edges
        s_req_valid = 1;
        tick(3);
        s_req_valid = 0;
        chk("cnt_three", 64'(outstanding), 3);
`ifdef ACCEL_THROTTLE_STATS_EN
        chk("stall_cycles", 64'(stall_cycles), 2);
        chk("resp_cnt", 64'(resp_cnt), 7);
`endif
        #1 rst = 1;
        #1;
        chk("async_cnt", 64'(outstanding), 0);
        chk("async_err", 64'(err), 0);
        chk("async_done", 64'(done), 0);
`ifdef ACCEL_THROTTLE_STATS_EN
        chk("async_stall", 64'(stall_cycles), 0);
`endif
        rst = 0;
        tick(1);
        // Error-flagged response at count 1
        s_req_valid = 1;
        tick(1);
        s_req_valid = 0;
        chk("cnt_one", 64'(outstanding), 1);
        m_resp_valid = 1; m_resp.error = 1;
        tick(1);
        m_resp_valid = 0; m_resp.error = 0;
        chk("errflag_err", 64'(err), 1);
        chk("errflag_cnt", 64'(outstanding), 0);
        // End of stream with one in flight
        s_req_valid = 1;
        tick(1);
        s_req_valid = 0;
        eos = 1;
        tick(1);
        chk("drain_not_done", 64'(done), 0);
        m_resp_valid = 1;
        tick(1);
        m_resp_valid = 0;
        chk("drain_cnt", 64'(outstanding), 0);
        tick(1);
        chk("busy_not_done", 64'(done), 0);
        ara_idle = 1;
        #1;
        chk("idle_not_yet", 64'(done), 0);
        tick(1);
        chk("done_set", 64'(done), 1);
        s_req_valid = 1;
        #1;
        chk("done_sready", 64'(s_req_ready), 0);
        chk("done_mvalid", 64'(m_req_valid), 0);
        tick(1);
        s_req_valid = 0;
        chk("done_cnt", 64'(outstanding), 0);
        eos = 0; m_resp_valid = 1;
        #1;
        chk("done_resp_fwd", 64'(s_resp_valid), 1);
        tick(1);
        m_resp_valid = 0;
        chk("done_sticky", 64'(done), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
